// File: rtl/serial_word_rx.sv
// Receive-side deserializer: rebuilds N-bit words from a framed 1-bit serial stream
// and presents each word on a valid/ready handshake, with overrun and framing flags.
module serial_word_rx #(
  parameter int N         = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         sin,
  input  logic         sin_valid,
  input  logic         sof,
  output logic [N-1:0] q,
  output logic         q_valid,
  input  logic         q_ready,
  output logic         overrun,
  output logic         frame_err,
  input  logic         clr_err
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RECV = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [1:0]    state_q,     state_d;
  logic [N-1:0]  shreg_q,     shreg_d;
  logic [CW-1:0] cnt_q,       cnt_d;
  logic [N-1:0]  q_q,         q_d;
  logic          q_valid_q,   q_valid_d;
  logic          overrun_q,   overrun_d;
  logic          frame_err_q, frame_err_d;

  logic [N-1:0]  shift_cur;
  logic [N-1:0]  shift_new;
  logic          ovr_set;
  logic          handshake;

  // Inserts one serial bit at the end of the word selected by MSB_FIRST.
  function automatic logic [N-1:0] shift_in(input logic [N-1:0] cur, input logic b);
    logic [N-1:0] r;
    r = cur;
    if (MSB_FIRST) begin
      for (int i = N - 1; i >= 1; i--) begin
        r[i] = cur[i-1];
      end
      r[0] = b;
    end else begin
      for (int i = 0; i <= N - 2; i++) begin
        r[i] = cur[i+1];
      end
      r[N-1] = b;
    end
    return r;
  endfunction

  assign shift_cur = shift_in(shreg_q, sin);
  assign shift_new = shift_in({N{1'b0}}, sin);
  assign handshake = q_valid_q && q_ready;

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    q_d         = q_q;
    q_valid_d   = q_valid_q;
    frame_err_d = 1'b0;
    ovr_set     = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Bits outside a frame are silently ignored until a sof arrives.
        if (sin_valid && sof) begin
          shreg_d = shift_new;
          cnt_d   = CNT_ONE;
          state_d = S_RECV;
        end
      end

      S_RECV: begin
        if (sin_valid && sof) begin
          // Restart: partial word dropped, the sof bit opens the new frame.
          shreg_d     = shift_new;
          cnt_d       = CNT_ONE;
          frame_err_d = 1'b1;
        end else if (sin_valid) begin
          shreg_d = shift_cur;
          if (cnt_q == CNT_LAST) begin
            q_d       = shift_cur;
            q_valid_d = 1'b1;
            cnt_d     = '0;
            state_d   = S_HOLD;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end

      S_HOLD: begin
        if (handshake) begin
          q_valid_d = 1'b0;
          if (sin_valid && sof) begin
            shreg_d = shift_new;
            cnt_d   = CNT_ONE;
            state_d = S_RECV;
          end else begin
            ovr_set = sin_valid;
            state_d = S_IDLE;
          end
        end else begin
          ovr_set = sin_valid;
        end
      end

      default: begin
        state_d   = S_IDLE;
        cnt_d     = '0;
        q_valid_d = 1'b0;
      end
    endcase

    // A new drop in the same cycle as a clear keeps the flag set.
    overrun_d = ovr_set | (overrun_q & ~clr_err);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      shreg_q     <= '0;
      cnt_q       <= '0;
      q_q         <= '0;
      q_valid_q   <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      q_q         <= q_d;
      q_valid_q   <= q_valid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign q         = q_q;
  assign q_valid   = q_valid_q;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_serial_word_rx.sv
// Bench for serial_word_rx: one MSB-first and one LSB-first instance on shared stimulus,
// directed scenarios plus randomized traffic against a frame-level reference model.
module tb_serial_word_rx;

  logic clock = 1'b0;
  logic reset_n = 1'b1;
  logic sin = 1'b0, sin_valid = 1'b0, sof = 1'b0, q_ready = 1'b0, clr_err = 1'b0;
  logic [7:0] q_m, q_l;
  logic qv_m, qv_l, ov_m, ov_l, fe_m, fe_l;

  int passed = 0;
  int total  = 0;

  // Reference model state: bits of the frame in progress and the last delivered word.
  bit         frame_q[$];
  logic [7:0] mq_msb = '0, mq_lsb = '0;
  logic       m_qv = 1'b0, m_ov = 1'b0, m_fe = 1'b0;

  serial_word_rx #(.N(8), .MSB_FIRST(1'b1)) dut_msb (
    .clock(clock), .reset_n(reset_n), .sin(sin), .sin_valid(sin_valid), .sof(sof),
    .q(q_m), .q_valid(qv_m), .q_ready(q_ready), .overrun(ov_m), .frame_err(fe_m),
    .clr_err(clr_err)
  );

  serial_word_rx #(.N(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clock(clock), .reset_n(reset_n), .sin(sin), .sin_valid(sin_valid), .sof(sof),
    .q(q_l), .q_valid(qv_l), .q_ready(q_ready), .overrun(ov_l), .frame_err(fe_l),
    .clr_err(clr_err)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] rev8(input logic [7:0] w);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = w[7-i];
    return r;
  endfunction

  task automatic model_reset();
    frame_q.delete();
    mq_msb = '0;
    mq_lsb = '0;
    m_qv   = 1'b0;
    m_ov   = 1'b0;
    m_fe   = 1'b0;
  endtask

  // Applies the current inputs to the model as one clock edge would.
  task automatic model_step();
    logic set_ov, fe;
    int wm, wl;
    set_ov = 1'b0;
    fe     = 1'b0;
    if (m_qv) begin
      if (q_ready) begin
        m_qv = 1'b0;
        if (sin_valid && sof) begin
          frame_q.delete();
          frame_q.push_back(sin);
        end else if (sin_valid) begin
          set_ov = 1'b1;
        end
      end else if (sin_valid) begin
        set_ov = 1'b1;
      end
    end else if (sin_valid) begin
      if (sof) begin
        fe = (frame_q.size() != 0);
        frame_q.delete();
        frame_q.push_back(sin);
      end else if (frame_q.size() != 0) begin
        frame_q.push_back(sin);
        if (frame_q.size() == 8) begin
          wm = 0;
          wl = 0;
          foreach (frame_q[k]) begin
            wm = wm * 2 + int'(frame_q[k]);
            wl = wl + (int'(frame_q[k]) << k);
          end
          mq_msb = wm[7:0];
          mq_lsb = wl[7:0];
          m_qv   = 1'b1;
          frame_q.delete();
        end
      end
    end
    m_fe = fe;
    m_ov = set_ov ? 1'b1 : (clr_err ? 1'b0 : m_ov);
  endtask

  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic s);
    sin_valid = 1'b1;
    sin       = b;
    sof       = s;
    tick();
  endtask

  task automatic idle();
    sin_valid = 1'b0;
    sof       = 1'b0;
    sin       = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    q_ready = 1'b0;
    clr_err = 1'b0;
    #2 reset_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    total++;
    if ({q_m, q_l} !== 16'h0000) $display("FAIL reset_q: got %h/%h expected 00/00", q_m, q_l);
    else passed++;
    total++;
    if ({qv_m, qv_l, ov_m, ov_l, fe_m, fe_l} !== 6'b0)
      $display("FAIL reset_flags: got %b expected 000000", {qv_m, qv_l, ov_m, ov_l, fe_m, fe_l});
    else passed++;
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_bit_order();
    logic [7:0] w;
    w = 8'hB2;
    q_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      send_bit(w[7-i], i == 0);
      if (i == 6) begin
        total++;
        if ({qv_m, qv_l} !== 2'b00) $display("FAIL order_early_valid: got %b expected 00", {qv_m, qv_l});
        else passed++;
      end
    end
    idle();
    total++;
    if ({qv_m, qv_l} !== 2'b11) $display("FAIL order_latency: got q_valid %b expected 11", {qv_m, qv_l});
    else passed++;
    total++;
    if (q_m !== 8'hB2) $display("FAIL order_msb: got %h expected b2", q_m);
    else passed++;
    total++;
    if (q_l !== 8'h4D) $display("FAIL order_lsb: got %h expected 4d", q_l);
    else passed++;
    for (int c = 0; c < 5; c++) begin
      tick();
      total++;
      if ({qv_m, qv_l, q_m, q_l} !== {2'b11, 8'hB2, 8'h4D})
        $display("FAIL hold_stable: got %b %h %h expected 11 b2 4d", {qv_m, qv_l}, q_m, q_l);
      else passed++;
    end
    q_ready = 1'b1;
    tick();
    total++;
    if ({qv_m, qv_l} !== 2'b00) $display("FAIL hold_release: got %b expected 00", {qv_m, qv_l});
    else passed++;
    for (int i = 0; i < 8; i++) send_bit(w[7-i], i == 0);
    idle();
    total++;
    if ({qv_m, q_m} !== {1'b1, 8'hB2}) $display("FAIL ready_word: got %b %h expected 1 b2", qv_m, q_m);
    else passed++;
    tick();
    total++;
    if ({qv_m, qv_l} !== 2'b00) $display("FAIL ready_one_cycle: got %b expected 00", {qv_m, qv_l});
    else passed++;
    q_ready = 1'b0;
  endtask

  task automatic test_frame_err();
    logic early;
    early = 1'b0;
    q_ready = 1'b1;
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    total++;
    if ({fe_m, fe_l} !== 2'b00) $display("FAIL ferr_quiet: got %b expected 00", {fe_m, fe_l});
    else passed++;
    send_bit(1'b1, 1'b1);
    total++;
    if ({fe_m, fe_l} !== 2'b11) $display("FAIL ferr_pulse: got %b expected 11", {fe_m, fe_l});
    else passed++;
    for (int i = 1; i < 8; i++) begin
      if (qv_m || qv_l) early = 1'b1;
      send_bit(1'b1, 1'b0);
      if (i == 1) begin
        total++;
        if ({fe_m, fe_l} !== 2'b00) $display("FAIL ferr_width: got %b expected 00", {fe_m, fe_l});
        else passed++;
      end
      if (i < 7 && (qv_m || qv_l)) early = 1'b1;
    end
    idle();
    total++;
    if (early !== 1'b0) $display("FAIL ferr_partial_word: got early valid %b expected 0", early);
    else passed++;
    total++;
    if ({qv_m, qv_l, q_m, q_l} !== {2'b11, 8'hFF, 8'hFF})
      $display("FAIL ferr_word: got %b %h %h expected 11 ff ff", {qv_m, qv_l}, q_m, q_l);
    else passed++;
    tick();
    q_ready = 1'b0;
  endtask

  task automatic test_overrun();
    logic [7:0] w;
    w = 8'hA5;
    q_ready = 1'b0;
    for (int i = 0; i < 8; i++) send_bit(w[7-i], i == 0);
    send_bit(1'b0, 1'b0);
    total++;
    if ({ov_m, ov_l} !== 2'b11) $display("FAIL ovr_set: got %b expected 11", {ov_m, ov_l});
    else passed++;
    send_bit(1'b1, 1'b0);
    idle();
    total++;
    if ({qv_m, q_m, q_l} !== {1'b1, 8'hA5, rev8(w)})
      $display("FAIL ovr_word_kept: got %b %h %h expected 1 a5 a5", qv_m, q_m, q_l);
    else passed++;
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    total++;
    if ({ov_m, ov_l} !== 2'b00) $display("FAIL ovr_clear: got %b expected 00", {ov_m, ov_l});
    else passed++;
    clr_err = 1'b1;
    send_bit(1'b1, 1'b0);
    clr_err = 1'b0;
    idle();
    total++;
    if ({ov_m, ov_l} !== 2'b11) $display("FAIL ovr_set_wins: got %b expected 11", {ov_m, ov_l});
    else passed++;
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    q_ready = 1'b1;
    send_bit(1'b0, 1'b0);
    idle();
    total++;
    if ({qv_m, ov_m, ov_l} !== 3'b011)
      $display("FAIL ovr_handshake_drop: got valid,ovr %b expected 011", {qv_m, ov_m, ov_l});
    else passed++;
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    q_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] a, b;
    a = 8'h3C;
    b = 8'hC3;
    q_ready = 1'b1;
    for (int i = 0; i < 8; i++) send_bit(a[7-i], i == 0);
    total++;
    if ({qv_m, qv_l, q_m} !== {2'b11, 8'h3C}) $display("FAIL b2b_first: got %b %h expected 11 3c", {qv_m, qv_l}, q_m);
    else passed++;
    for (int i = 0; i < 8; i++) begin
      send_bit(b[7-i], i == 0);
      if (i == 0) begin
        total++;
        if ({qv_m, qv_l} !== 2'b00) $display("FAIL b2b_accept: got %b expected 00", {qv_m, qv_l});
        else passed++;
      end
    end
    idle();
    total++;
    if ({qv_m, qv_l, q_m, q_l} !== {2'b11, 8'hC3, rev8(b)})
      $display("FAIL b2b_second: got %b %h %h expected 11 c3 c3", {qv_m, qv_l}, q_m, q_l);
    else passed++;
    tick();
    q_ready = 1'b0;
  endtask

  task automatic test_reset_midframe();
    logic [7:0] w;
    logic stray;
    w = 8'h81;
    stray = 1'b0;
    q_ready = 1'b1;
    for (int i = 0; i < 4; i++) send_bit(w[7-i], i == 0);
    idle();
    reset_n = 1'b0;
    model_reset();
    #2;
    total++;
    if ({qv_m, qv_l, ov_m, ov_l, fe_m, fe_l, q_m, q_l} !== 22'b0)
      $display("FAIL midreset_outputs: got %b %h %h expected all zero", {qv_m, qv_l, ov_m, ov_l, fe_m, fe_l}, q_m, q_l);
    else passed++;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    for (int i = 4; i < 8; i++) begin
      send_bit(w[7-i], 1'b0);
      if (qv_m || qv_l) stray = 1'b1;
    end
    idle();
    repeat (3) begin
      tick();
      if (qv_m || qv_l) stray = 1'b1;
    end
    total++;
    if (stray !== 1'b0) $display("FAIL midreset_stray_word: got %b expected 0", stray);
    else passed++;
    for (int i = 0; i < 8; i++) send_bit(w[7-i], i == 0);
    idle();
    total++;
    if ({qv_m, qv_l, q_m, q_l} !== {2'b11, 8'h81, rev8(w)})
      $display("FAIL midreset_word: got %b %h %h expected 11 81 81", {qv_m, qv_l}, q_m, q_l);
    else passed++;
    tick();
    q_ready = 1'b0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      sin_valid = ($urandom_range(3) != 0);
      sof       = ($urandom_range(11) == 0);
      sin       = $urandom_range(1);
      q_ready   = ($urandom_range(2) != 0);
      clr_err   = ($urandom_range(15) == 0);
      tick();
      total++;
      if ({qv_m, qv_l} !== {m_qv, m_qv}) $display("FAIL rand_valid c=%0d: got %b expected %b", c, {qv_m, qv_l}, {m_qv, m_qv});
      else passed++;
      total++;
      if ({q_m, q_l} !== {mq_msb, mq_lsb}) $display("FAIL rand_q c=%0d: got %h/%h expected %h/%h", c, q_m, q_l, mq_msb, mq_lsb);
      else passed++;
      total++;
      if ({ov_m, ov_l} !== {m_ov, m_ov}) $display("FAIL rand_overrun c=%0d: got %b expected %b", c, {ov_m, ov_l}, {m_ov, m_ov});
      else passed++;
      total++;
      if ({fe_m, fe_l} !== {m_fe, m_fe}) $display("FAIL rand_frame_err c=%0d: got %b expected %b", c, {fe_m, fe_l}, {m_fe, m_fe});
      else passed++;
    end
    idle();
    clr_err = 1'b0;
  endtask

  initial begin
    test_reset();
    test_bit_order();
    test_frame_err();
    test_overrun();
    test_back_to_back();
    test_reset_midframe();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
